// File: rtl/ip_setup_ctrl.sv
// rtl/ip_setup_ctrl.sv - IPM setup generator: RNG-fed vector L and product matrix L_hat via one shared gmul8
// Optional IPSETUP_SYM_EN: iterate only the upper triangle of L_hat and mirror each product.
module ip_setup_ctrl #(
   parameter int V = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         rnd_data,
   input  logic               rnd_valid,
   output logic               rnd_ready,
   output logic               busy,
   output logic               done,
   output logic               setup_valid,
   output logic [V*8-1:0]     L,
   output logic [V*V*8-1:0]   L_hat,
   output logic [7:0]         rej_cnt
);

   localparam int KW = (V > 2) ? $clog2(V) : 1;
   localparam logic [KW-1:0] LAST = KW'(V - 1);

   typedef enum logic [1:0] {IDLE, FILL, MUL, DONE} state_t;

   state_t        state;
   logic [7:0]    l_mem  [V];
   logic [7:0]    lh_mem [V][V];
   logic [KW-1:0] k;
   logic [KW-1:0] i;
   logic [KW-1:0] j;
   logic [7:0]    prod;

   // GF(2^8) multiply, AES reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   assign prod = gmul8(l_mem[i], l_mem[j]);

   for (genvar a = 0; a < V; a++) begin : g_pack
      assign L[8*a +: 8] = l_mem[a];
      for (genvar b = 0; b < V; b++) begin : g_pack_hat
         assign L_hat[8*(a*V+b) +: 8] = lh_mem[a][b];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         k           <= KW'(1);
         i           <= '0;
         j           <= '0;
         rnd_ready   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         setup_valid <= 1'b0;
         rej_cnt     <= 8'h00;
         for (int a = 0; a < V; a++) begin
            l_mem[a] <= (a == 0) ? 8'h01 : 8'h00;
            for (int b = 0; b < V; b++) lh_mem[a][b] <= 8'h00;
         end
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state       <= FILL;
                  rnd_ready   <= 1'b1;
                  busy        <= 1'b1;
                  setup_valid <= 1'b0;
                  rej_cnt     <= 8'h00;
                  k           <= KW'(1);
               end
            end
            FILL: begin
               if (rnd_valid && rnd_ready) begin
                  if (rnd_data == 8'h00) begin
                     if (rej_cnt != 8'hff) rej_cnt <= rej_cnt + 8'd1;
                  end else begin
                     l_mem[k] <= rnd_data;
                     if (k == LAST) begin
                        state     <= MUL;
                        rnd_ready <= 1'b0;
                        i         <= '0;
                        j         <= '0;
                     end else begin
                        k <= k + KW'(1);
                     end
                  end
               end
            end
            MUL: begin
               lh_mem[i][j] <= prod;
`ifdef IPSETUP_SYM_EN
               // gmul8 is commutative, so one product fills both mirror entries
               lh_mem[j][i] <= prod;
               if (j == LAST) begin
                  if (i == LAST) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     setup_valid <= 1'b1;
                  end else begin
                     i <= i + KW'(1);
                     j <= i + KW'(1);
                  end
               end else begin
                  j <= j + KW'(1);
               end
`else
               if (j == LAST) begin
                  j <= '0;
                  if (i == LAST) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     setup_valid <= 1'b1;
                  end else begin
                     i <= i + KW'(1);
                  end
               end else begin
                  j <= j + KW'(1);
               end
`endif
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ip_setup_ctrl.sv
// tb/tb_ip_setup_ctrl.sv - self-checking bench for ip_setup_ctrl (table-driven runs plus reset corner case)
module tb_ip_setup_ctrl;
   localparam int V  = 8;
   localparam int CW = V*V*8;
`ifdef IPSETUP_SYM_EN
   localparam int MUL_LEN = V*(V+1)/2;
`else
   localparam int MUL_LEN = V*V;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [7:0]       rnd_data;
   logic             rnd_valid;
   logic             rnd_ready;
   logic             busy;
   logic             done;
   logic             setup_valid;
   logic [V*8-1:0]   L;
   logic [V*V*8-1:0] L_hat;
   logic [7:0]       rej_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] lq[$];

   typedef struct {
      int         lead;
      int         za;
      int         zb;
      bit         tog;
      bit         spam;
      logic [7:0] base;
      logic [7:0] step;
      int         extra;
      int         exp_rej;
   } vec_t;

   vec_t tbl[5];

   always #5 clk = ~clk;

   ip_setup_ctrl #(.V(V)) dut (
      .clk(clk), .rst(rst), .start(start), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
      .rnd_ready(rnd_ready), .busy(busy), .done(done), .setup_valid(setup_valid),
      .L(L), .L_hat(L_hat), .rej_cnt(rej_cnt)
   );

   // carry-less product then polynomial reduction by 0x11b from the top bit down
   function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int n = 0; n < 8; n++) if (b[n]) p = p ^ (15'(a) << n);
      for (int t = 14; t >= 8; t--) if (p[t]) p = p ^ (15'h11b << (t - 8));
      return p[7:0];
   endfunction

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      logic [V*8-1:0] exp_l;
      exp_l = '0;
      exp_l[7:0] = 8'h01;
      check({tag, "_L"}, CW'(L), CW'(exp_l));
      check({tag, "_L_hat"}, L_hat, '0);
      check({tag, "_ctrl"}, CW'({rnd_ready, busy, done, setup_valid}), '0);
      check({tag, "_rej_cnt"}, CW'(rej_cnt), '0);
   endtask

   task automatic run(input vec_t v, input string tag);
      logic [7:0] stream[$];
      logic [7:0] expl[V];
      int n, pos, idx, cyc, done_cyc, dones, busy_bad, lh_bad;
      bit hs, exp_busy;
      n = 0;
      pos = 0;
      while (n < V - 1) begin
         if (pos < v.lead || pos == v.za || pos == v.zb) begin
            stream.push_back(8'h00);
         end else begin
            logic [7:0] b;
            b = v.base + 8'(int'(v.step) * n);
            stream.push_back((b == 8'h00) ? 8'hff : b);
            n++;
         end
         pos++;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; idx = 0; done_cyc = -1; dones = 0; busy_bad = 0;
      while (cyc < 2000 && (done_cyc < 0 || cyc <= done_cyc + 1)) begin
         rnd_valid = v.tog ? (cyc % 2 == 0) : 1'b1;
         rnd_data  = (idx < stream.size()) ? stream[idx] : 8'h5a;
         start     = (v.spam && cyc >= V + 3 && cyc < V + 30) ? (cyc % 2 == 1) : 1'b0;
         @(negedge clk);
         if (cyc == 1) check({tag, "_setup_valid_cleared"}, CW'(setup_valid), '0);
         if (done) begin
            dones++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               check({tag, "_setup_valid_with_done"}, CW'(setup_valid), CW'(1));
            end
         end
         exp_busy = (done_cyc < 0 || cyc == done_cyc);
         if (busy !== exp_busy) busy_bad++;
         hs = rnd_valid && rnd_ready;
         if (hs && rnd_data != 8'h00) lq.push_back(rnd_data);
         @(posedge clk); #1;
         if (hs) idx++;
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, CW'(done_cyc), CW'(V + MUL_LEN + v.extra));
      check({tag, "_done_pulses"}, CW'(dones), CW'(1));
      check({tag, "_busy_window"}, CW'(busy_bad), '0);
      check({tag, "_rej_cnt"}, CW'(rej_cnt), CW'(v.exp_rej));
      check({tag, "_setup_valid_held"}, CW'(setup_valid), CW'(1));
      expl[0] = 8'h01;
      check({tag, "_L0"}, CW'(L[7:0]), CW'(8'h01));
      for (int kk = 1; kk < V; kk++) begin
         if (lq.size() == 0) begin
            check({tag, "_L_scoreboard_underflow"}, CW'(kk), '0);
            expl[kk] = 8'h00;
         end else begin
            expl[kk] = lq.pop_front();
            check($sformatf("%s_L%0d", tag, kk), CW'(L[8*kk +: 8]), CW'(expl[kk]));
         end
      end
      check({tag, "_L_scoreboard_left"}, CW'(lq.size()), '0);
      lq.delete();
      lh_bad = 0;
      for (int a = 0; a < V; a++)
         for (int b = 0; b < V; b++)
            if (L_hat[8*(a*V+b) +: 8] !== ref_gmul(expl[a], expl[b])) lh_bad++;
      check({tag, "_L_hat_bad_entries"}, CW'(lh_bad), '0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_data = 8'h00;
      tbl[0] = '{lead: 0,   za: -1, zb: -1, tog: 0, spam: 0, base: 8'h02, step: 8'h01, extra: 0,   exp_rej: 0};
      tbl[1] = '{lead: 0,   za: 2,  zb: 5,  tog: 0, spam: 0, base: 8'h02, step: 8'h01, extra: 2,   exp_rej: 2};
      tbl[2] = '{lead: 0,   za: -1, zb: -1, tog: 1, spam: 0, base: 8'h02, step: 8'h01, extra: V-1, exp_rej: 0};
      tbl[3] = '{lead: 0,   za: -1, zb: -1, tog: 0, spam: 1, base: 8'h53, step: 8'h37, extra: 0,   exp_rej: 0};
      tbl[4] = '{lead: 300, za: -1, zb: -1, tog: 0, spam: 0, base: 8'hc1, step: 8'h2d, extra: 300, exp_rej: 255};

      #12;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int t = 0; t < 5; t++) begin
         run(tbl[t], $sformatf("vec%0d", t));
         if (t == 0) check("vec0_L_hat_1_2", CW'(L_hat[8*(1*V+2) +: 8]), CW'(8'h06));
         repeat (2) @(posedge clk);
         #1;
      end

      // asynchronous reset in the middle of MUL
      begin
         int dones;
         int busy_bad;
         start = 1'b1;
         rnd_valid = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         for (int c = 1; c < V + 20; c++) begin
            rnd_data = 8'(c + 1);
            @(posedge clk); #1;
         end
         #2;
         rst = 1'b1;
         #1;
         check_reset_state("midmul_rst");
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         dones = 0;
         busy_bad = 0;
         for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy !== 1'b0 || setup_valid !== 1'b0) busy_bad++;
         end
         check("midmul_rst_no_done", CW'(dones), '0);
         check("midmul_rst_stays_idle", CW'(busy_bad), '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
